game_sequencer: RTL and testbench
=================================

# game_sequencer

Central game controller for the Flappy VGA design. It replaces the divided-clock tick scheme with single-clock enables. It debounces the Start/Ack and Jump buttons and runs the IDLE/ARM/PLAY/OVER game state machine. It issues frame-aligned scroll and physics ticks to the pipe RAM and flight physics, and keeps the BCD score and high score for the seven-segment display.

## Interface
Parameters:
- DEB_CYCLES, 1000000: cycles a synchronized button must hold a new level before the debounced level follows (20 ms at 50 MHz).
- SCROLL_DIV, 524288: cycles between pipe-scroll tick requests.
- PHYS_DIV, 1048576: cycles between physics tick requests.

Ports:
- Clk, in, 1: system clock (board_clk, 50 MHz).
- reset, in, 1: synchronous, active-high.
- Start_Btn, in, 1: raw asynchronous button; Start in IDLE, Ack in OVER.
- Jump_Btn, in, 1: raw asynchronous button.
- Frame_Start, in, 1: one-cycle pulse at the first blanking line after the visible area, from the sync generator.
- Lose, in, 1: collision level from obstacle_logic.
- Pipe_Passed, in, 1: one-cycle pulse from pipe RAM when a pipe leaves scope.
- Game_Clear, out, 1: one-cycle datapath clear; pipes and bird return to their start positions.
- Pipe_Tick, out, 1: one-cycle scroll enable.
- Phys_Tick, out, 1: one-cycle physics enable.
- Jump_Req, out, 1: pending jump, consumed by Phys_Tick.
- Q_Idle, Q_Arm, Q_Play, Q_Over, out, 1 each: one-hot state.
- Score, out, 8: two BCD digits {tens, ones}.
- High_Score, out, 8: two BCD digits.

## Operation
- **Button path**, identical for both buttons:
  - 2-flop synchronizer.
  - Debouncer: the counter resets whenever the synchronized value equals the debounced level. The debounced level flips when the counter reaches DEB_CYCLES-1.
  - Rising-edge detector: a registered press pulse one cycle after the debounced level rises. A release produces no pulse.
- **FSM**, one-hot, reset state IDLE:
  - IDLE: on a start press, go to ARM. Lose and Pipe_Passed are ignored.
  - ARM: lasts exactly one cycle. Game_Clear=1. Score, both dividers, both pending flags and Jump_Req are cleared. Next state is PLAY.
  - PLAY: on Lose=1, go to OVER. Lose takes priority over any same-cycle tick or Pipe_Passed; those events are dropped. A start press in PLAY is ignored.
  - OVER: on a start press (Ack), go to IDLE. Score is held.
- **Dividers**:
  - Count only in PLAY. Each wraps from DIV-1 to 0 and sets its pending flag on the wrap.
  - Extra wraps while a flag is already pending are merged into one.
- **Tick issue**:
  - Pipe_Tick is registered. It goes high the cycle after Frame_Start=1 if the pipe flag was pending or wrapping in that cycle, and the flag is cleared at that point.
  - Phys_Tick follows the same rule with its own flag.
  - Both ticks may fire in the same cycle. Ticks are never issued outside PLAY.
- **Jump**:
  - A jump press in PLAY sets Jump_Req. The cycle after Phys_Tick, Jump_Req is cleared.
  - If a press coincides with the Phys_Tick cycle, Jump_Req stays set for the next tick.
  - Jump presses outside PLAY are discarded.
- **Score**:
  - Pipe_Passed in PLAY increments the BCD score: ones wrap 9 to 0 with a carry into tens. The score saturates at 0x99.
  - On the PLAY to OVER transition, if Score > High_Score (binary compare of the BCD bytes is valid), High_Score is loaded with Score.

## Timing
- **Reset**:
  - State is IDLE: Q_Idle=1, other state outputs 0.
  - All other outputs are 0, including Score and High_Score.
  - Debounced levels, counters and pending flags are 0.
  - Reset in the middle of a game returns to IDLE on the next edge and clears High_Score.
- **Press latency**: the press pulse occurs 2 (sync) + DEB_CYCLES + 1 cycles after a clean raw rising edge. The FSM transitions on the edge after the pulse.
- **Game_Clear**: high for exactly the ARM cycle. Q_Play rises on the next edge.
- **Tick latency**: 1 cycle after Frame_Start.
- **Lose**: Q_Over is set on the edge after Lose is sampled high in PLAY. Any tick that would have issued that same edge is suppressed.
- **Score**: updates on the edge after Pipe_Passed. High_Score updates on the same edge at which Q_Over rises.

## Test plan
Run the bench with DEB_CYCLES=4, SCROLL_DIV=8, PHYS_DIV=16.
- **Start sequence**: reset, then hold Start_Btn high for 10 cycles. Required: Q_Arm is high for 1 cycle together with Game_Clear=1, then Q_Play=1. A 3-cycle glitch on Start_Btn causes no transition.
- **Frame alignment**: in PLAY with Frame_Start every 40 cycles, expect exactly one Pipe_Tick and one Phys_Tick per frame, each 1 cycle after Frame_Start. Multiple divider wraps between frames do not produce extra ticks.
- **Jump**: a jump press in PLAY raises Jump_Req, which clears the cycle after the next Phys_Tick. A jump press in IDLE leaves Jump_Req=0.
- **Score BCD**: 9 Pipe_Passed pulses give Score=0x09, the 10th gives 0x10, and 120 pulses give 0x99.
- **Lose and high score**:
  - Score=0x12, then Lose=1 with Frame_Start coincident. Required: Q_Over=1, no tick, High_Score=0x12.
  - Next game ends with Score=0x05. Required: High_Score stays 0x12.
  - Ack press in OVER returns the FSM to IDLE.
- **Mid-game reset**: assert reset in PLAY with Score=0x07. Required: next edge Q_Idle=1 and all outputs 0.

Source files
------------

// File: rtl/game_sequencer.sv
// Flappy VGA game controller: button conditioning, IDLE/ARM/PLAY/OVER sequencing,
// frame-aligned scroll/physics enables and BCD score keeping on a single clock.
module game_sequencer #(
  parameter int DEB_CYCLES = 1000000,
  parameter int SCROLL_DIV = 524288,
  parameter int PHYS_DIV   = 1048576
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start_Btn,
  input  logic       Jump_Btn,
  input  logic       Frame_Start,
  input  logic       Lose,
  input  logic       Pipe_Passed,
  output logic       Game_Clear,
  output logic       Pipe_Tick,
  output logic       Phys_Tick,
  output logic       Jump_Req,
  output logic       Q_Idle,
  output logic       Q_Arm,
  output logic       Q_Play,
  output logic       Q_Over,
  output logic [7:0] Score,
  output logic [7:0] High_Score
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int SCR_W = $clog2(SCROLL_DIV + 1);
  localparam int PHY_W = $clog2(PHYS_DIV + 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ARM  = 4'b0010,
    ST_PLAY = 4'b0100,
    ST_OVER = 4'b1000
  } state_t;

  // Saturating two-digit BCD increment; 0x99 holds.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  logic [1:0]       btn_raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       deb_lvl;
  logic [1:0]       deb_lvl_d;
  logic [1:0]       press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic             start_press;
  logic             jump_press;

  state_t           state;
  state_t           state_nxt;

  logic             in_play;
  logic             lose_now;
  logic             live;

  logic [SCR_W-1:0] scr_cnt;
  logic [PHY_W-1:0] phy_cnt;
  logic             pipe_pend;
  logic             phys_pend;
  logic             pipe_wrap;
  logic             phys_wrap;
  logic             pipe_issue;
  logic             phys_issue;

  assign btn_raw = {Jump_Btn, Start_Btn};

  // Stage p0/p1: two-flop synchronizer, then debounce and rising-edge press pulse.
  always_ff @(posedge Clk) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      deb_lvl    <= '0;
      deb_lvl_d  <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      deb_lvl_d <= deb_lvl;
      press     <= deb_lvl & ~deb_lvl_d;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_lvl[i] <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign start_press = press[0];
  assign jump_press  = press[1];

  always_ff @(posedge Clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_press) state_nxt = ST_ARM;
      ST_ARM:  state_nxt = ST_PLAY;
      ST_PLAY: if (Lose) state_nxt = ST_OVER;
      ST_OVER: if (start_press) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Q_Idle     = (state == ST_IDLE);
  assign Q_Arm      = (state == ST_ARM);
  assign Q_Play     = (state == ST_PLAY);
  assign Q_Over     = (state == ST_OVER);
  assign Game_Clear = (state == ST_ARM);

  // A collision cycle swallows every same-cycle tick and pipe event.
  assign in_play  = (state == ST_PLAY);
  assign lose_now = in_play & Lose;
  assign live     = in_play & ~Lose;

  assign pipe_wrap  = in_play && (scr_cnt == SCR_W'(SCROLL_DIV - 1));
  assign phys_wrap  = in_play && (phy_cnt == PHY_W'(PHYS_DIV - 1));
  assign pipe_issue = live && Frame_Start && (pipe_pend || pipe_wrap);
  assign phys_issue = live && Frame_Start && (phys_pend || phys_wrap);

  // Stage p2: dividers, pending flags, registered ticks, jump latch and score.
  always_ff @(posedge Clk) begin
    if (reset) begin
      scr_cnt    <= '0;
      phy_cnt    <= '0;
      pipe_pend  <= 1'b0;
      phys_pend  <= 1'b0;
      Pipe_Tick  <= 1'b0;
      Phys_Tick  <= 1'b0;
      Jump_Req   <= 1'b0;
      Score      <= '0;
      High_Score <= '0;
    end else if (state == ST_ARM) begin
      scr_cnt   <= '0;
      phy_cnt   <= '0;
      pipe_pend <= 1'b0;
      phys_pend <= 1'b0;
      Pipe_Tick <= 1'b0;
      Phys_Tick <= 1'b0;
      Jump_Req  <= 1'b0;
      Score     <= '0;
    end else begin
      Pipe_Tick <= pipe_issue;
      Phys_Tick <= phys_issue;
      if (in_play) begin
        scr_cnt   <= pipe_wrap ? '0 : scr_cnt + 1'b1;
        phy_cnt   <= phys_wrap ? '0 : phy_cnt + 1'b1;
        pipe_pend <= pipe_issue ? 1'b0 : (pipe_pend | pipe_wrap);
        phys_pend <= phys_issue ? 1'b0 : (phys_pend | phys_wrap);
      end
      // A press landing on the consuming tick survives for the next tick.
      if (!in_play)
        Jump_Req <= 1'b0;
      else if (jump_press)
        Jump_Req <= 1'b1;
      else if (Phys_Tick)
        Jump_Req <= 1'b0;
      if (live && Pipe_Passed)
        Score <= bcd_inc(Score);
      if (lose_now && (Score > High_Score))
        High_Score <= Score;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed stimulus queues expected outputs
// keyed by clock edge; a negedge monitor pops and compares them.
module tb_game_sequencer;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Start_Btn = 1'b0;
  logic       Jump_Btn = 1'b0;
  logic       Frame_Start = 1'b0;
  logic       Lose = 1'b0;
  logic       Pipe_Passed = 1'b0;
  logic       Game_Clear, Pipe_Tick, Phys_Tick, Jump_Req;
  logic       Q_Idle, Q_Arm, Q_Play, Q_Over;
  logic [7:0] Score, High_Score;

  game_sequencer #(
    .DEB_CYCLES(4),
    .SCROLL_DIV(8),
    .PHYS_DIV  (16)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .Start_Btn  (Start_Btn),
    .Jump_Btn   (Jump_Btn),
    .Frame_Start(Frame_Start),
    .Lose       (Lose),
    .Pipe_Passed(Pipe_Passed),
    .Game_Clear (Game_Clear),
    .Pipe_Tick  (Pipe_Tick),
    .Phys_Tick  (Phys_Tick),
    .Jump_Req   (Jump_Req),
    .Q_Idle     (Q_Idle),
    .Q_Arm      (Q_Arm),
    .Q_Play     (Q_Play),
    .Q_Over     (Q_Over),
    .Score      (Score),
    .High_Score (High_Score)
  );

  always #5 Clk = ~Clk;

  localparam logic [23:0] M_GC   = 24'h800000;
  localparam logic [23:0] M_PT   = 24'h400000;
  localparam logic [23:0] M_PH   = 24'h200000;
  localparam logic [23:0] M_JR   = 24'h100000;
  localparam logic [23:0] M_ST   = 24'h0F0000;
  localparam logic [23:0] M_SC   = 24'h00FF00;
  localparam logic [23:0] M_HS   = 24'h0000FF;
  localparam logic [23:0] M_ALL  = 24'hFFFFFF;
  localparam logic [23:0] S_IDLE = 24'h080000;
  localparam logic [23:0] S_ARM  = 24'h040000;
  localparam logic [23:0] S_PLAY = 24'h020000;
  localparam logic [23:0] S_OVER = 24'h010000;

  logic [23:0] obs;
  assign obs = {Game_Clear, Pipe_Tick, Phys_Tick, Jump_Req,
                Q_Idle, Q_Arm, Q_Play, Q_Over, Score, High_Score};

  int unsigned edges = 0;
  always @(posedge Clk) edges <= edges + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        flush = 1'b0;
  int unsigned q_at[$];
  logic [23:0] q_mask[$];
  logic [23:0] q_val[$];
  string       q_name[$];

  function automatic logic [23:0] sc(input logic [7:0] s);
    return {8'h00, s, 8'h00};
  endfunction

  function automatic logic [23:0] hs(input logic [7:0] s);
    return {16'h0000, s};
  endfunction

  // Expect obs (under mask) to equal val once k more rising edges have occurred.
  task automatic expect_at(input int k, input logic [23:0] mask,
                           input logic [23:0] val, input string name);
    q_at.push_back(edges + k);
    q_mask.push_back(mask);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  always @(negedge Clk) begin
    for (int i = q_at.size() - 1; i >= 0; i--) begin
      if (q_at[i] <= edges || flush) begin
        n_checks++;
        if (q_at[i] != edges) begin
          n_fail++;
          $display("FAIL %s: due at edge %0d, not compared (edge %0d)", q_name[i], q_at[i], edges);
        end else if ((obs & q_mask[i]) !== (q_val[i] & q_mask[i])) begin
          n_fail++;
          $display("FAIL %s @edge %0d: actual %h required %h (mask %h)",
                   q_name[i], edges, obs & q_mask[i], q_val[i] & q_mask[i], q_mask[i]);
        end
        q_at.delete(i);
        q_mask.delete(i);
        q_val.delete(i);
        q_name.delete(i);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic start_game();
    Start_Btn = 1'b1;
    expect_at(7, M_ST | M_GC, S_IDLE, "start_pre");
    expect_at(8, M_ST | M_GC, S_ARM | M_GC, "start_arm");
    expect_at(9, M_ST | M_GC | M_SC | M_JR, S_PLAY, "start_play");
    cyc(10);
    Start_Btn = 1'b0;
    cyc(10);
  endtask

  task automatic ack_over();
    Start_Btn = 1'b1;
    expect_at(7, M_ST, S_OVER, "ack_pre");
    expect_at(8, M_ST, S_IDLE, "ack_idle");
    cyc(10);
    Start_Btn = 1'b0;
    cyc(10);
  endtask

  task automatic pass_pipes(input int n, input int c0, input logic [7:0] v0,
                            input int c1, input logic [7:0] v1);
    for (int i = 1; i <= n; i++) begin
      Pipe_Passed = 1'b1;
      if (i == c0) expect_at(1, M_SC, sc(v0), "score_cp0");
      if (i == c1) expect_at(1, M_SC, sc(v1), "score_cp1");
      cyc(1);
      Pipe_Passed = 1'b0;
      cyc(1);
    end
  endtask

  task automatic lose_game(input logic [7:0] s, input logic [7:0] h, input logic coincide);
    Lose        = 1'b1;
    Frame_Start = coincide;
    Pipe_Passed = coincide;
    expect_at(1, M_ST | M_PT | M_PH | M_SC | M_HS, S_OVER | sc(s) | hs(h), "lose_over");
    cyc(1);
    Lose        = 1'b0;
    Frame_Start = 1'b0;
    Pipe_Passed = 1'b0;
    expect_at(1, M_ST | M_HS, S_OVER | hs(h), "over_hold");
    cyc(2);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    expect_at(0, M_ALL, S_IDLE, "reset_state");

    // IDLE ignores collisions and pipe events
    Lose = 1'b1;
    Pipe_Passed = 1'b1;
    expect_at(1, M_ST | M_SC, S_IDLE, "idle_ignore");
    cyc(1);
    Lose = 1'b0;
    Pipe_Passed = 1'b0;
    cyc(2);

    // 3-cycle glitch must not start a game
    Start_Btn = 1'b1;
    cyc(3);
    Start_Btn = 1'b0;
    for (int k = 1; k <= 9; k++) expect_at(k, M_ST | M_GC, S_IDLE, "glitch");
    cyc(10);

    // jump press in IDLE is discarded
    Jump_Btn = 1'b1;
    expect_at(8, M_JR, 24'h0, "jump_idle_a");
    expect_at(9, M_JR, 24'h0, "jump_idle_b");
    cyc(10);
    Jump_Btn = 1'b0;
    cyc(10);

    // game 1
    start_game();
    cyc(10);
    for (int f = 0; f < 3; f++) begin
      Frame_Start = 1'b1;
      expect_at(1, M_PT | M_PH, M_PT | M_PH, "frame_tick");
      cyc(1);
      Frame_Start = 1'b0;
      for (int k = 1; k <= 39; k++) expect_at(k, M_PT | M_PH, 24'h0, "frame_quiet");
      cyc(39);
    end

    Jump_Btn = 1'b1;
    expect_at(7, M_JR, 24'h0, "jump_pre");
    expect_at(8, M_JR, M_JR, "jump_set");
    cyc(10);
    Jump_Btn = 1'b0;
    Frame_Start = 1'b1;
    expect_at(1, M_PH | M_JR, M_PH | M_JR, "jump_tick");
    cyc(1);
    Frame_Start = 1'b0;
    expect_at(1, M_PH | M_JR, 24'h0, "jump_consumed");
    cyc(1);
    cyc(8);

    Jump_Btn = 1'b1;
    cyc(6);
    Frame_Start = 1'b1;
    expect_at(1, M_PH | M_JR, M_PH, "coinc_tick");
    expect_at(2, M_PH | M_JR, M_JR, "coinc_keep");
    expect_at(3, M_JR, M_JR, "coinc_hold");
    cyc(1);
    Frame_Start = 1'b0;
    cyc(3);
    Jump_Btn = 1'b0;
    cyc(8);

    pass_pipes(12, 9, 8'h09, 10, 8'h10);
    lose_game(8'h12, 8'h12, 1'b1);
    ack_over();

    // game 2: lower score keeps high score
    start_game();
    pass_pipes(5, 4, 8'h04, 5, 8'h05);
    lose_game(8'h05, 8'h12, 1'b0);
    ack_over();

    // game 3: saturation
    start_game();
    pass_pipes(120, 99, 8'h99, 120, 8'h99);
    lose_game(8'h99, 8'h99, 1'b0);
    ack_over();

    // game 4: reset mid-game
    start_game();
    pass_pipes(7, 1, 8'h01, 7, 8'h07);
    reset = 1'b1;
    expect_at(1, M_ALL, S_IDLE, "midgame_reset");
    cyc(1);
    reset = 1'b0;
    cyc(2);

    for (int w = 0; w < 100 && q_at.size() != 0; w++) cyc(1);
    flush = 1'b1;
    cyc(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
